// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the second-generation camera capture path.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capState_t;

  localparam logic [1:0] DECIM_1 = 2'b00;
  localparam logic [1:0] DECIM_2 = 2'b01;
  localparam logic [1:0] DECIM_4 = 2'b10;

  localparam int FMT_332 = 8;
  localparam int FMT_444 = 12;
  localparam int FMT_565 = 16;

  // Low-bit mask for "index mod D == 0"; code 11 falls back to 1:1.
  function automatic logic [1:0] decimMask(input logic [1:0] code);
    case (code)
      DECIM_2: decimMask = 2'b01;
      DECIM_4: decimMask = 2'b11;
      default: decimMask = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Byte pairing into RGB565 words, odd-byte line detection and output format conversion.
module cam_px_pack
  import cam_capture_pkg::*;
#(
  parameter int DW = FMT_332
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_pclkRise,
  input  logic          i_href,
  input  logic          i_hrefFall,
  input  logic [7:0]    i_data,
  output logic          o_wordValid,
  output logic [DW-1:0] o_px,
  output logic          o_oddByte
);

  logic        r_phase;
  logic        r_oddByte;
  logic [7:0]  r_hiByte;
  logic [15:0] w_word;
  logic        w_unusedWordBits;

  assign w_word           = {r_hiByte, i_data};
  assign w_unusedWordBits = ^w_word;
  assign o_wordValid      = i_en & i_pclkRise & i_href & r_phase;
  assign o_oddByte        = r_oddByte;

  // A line that ends between the two bytes of a word leaves the phase at 1.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_phase   <= 1'b0;
      r_oddByte <= 1'b0;
      r_hiByte  <= '0;
    end else if (i_en) begin
      if (i_pclkRise && i_href) begin
        if (!r_phase) r_hiByte <= i_data;
        r_phase <= ~r_phase;
      end else if (i_hrefFall && r_phase) begin
        r_oddByte <= 1'b1;
        r_phase   <= 1'b0;
      end
    end
  end

  generate
    if (DW == FMT_332) begin : g_fmt332
      assign o_px = {w_word[15:13], w_word[10:8], w_word[4:3]};
    end else if (DW == FMT_444) begin : g_fmt444
      assign o_px = {w_word[15:12], w_word[10:7], w_word[4:1]};
    end else if (DW == FMT_565) begin : g_fmt565
      assign o_px = w_word;
    end else begin : g_fmtBad
      $error("cam_px_pack: DW must be 8, 12 or 16");
    end
  endgenerate

endmodule

// File: rtl/cam_capture_gen2.sv
// Camera capture top: pin synchronisers, capture FSM, decimation and frame-buffer write port.
// Optional running checksum output is enabled with CAM_CAPTURE_CKSUM_EN.
module cam_capture_gen2
  import cam_capture_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = FMT_332
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          continuous,
  input  logic [1:0]    decim,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    frame_cnt,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_px_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
`ifdef CAM_CAPTURE_CKSUM_EN
  output logic          mem_we,
  output logic [15:0]   cksum
`else
  output logic          mem_we
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int IW   = AW + 2;
  localparam logic [IW-1:0] NPIX_V = IW'(NPIX);

  generate
    if ((64'd1 << AW) < 64'(NPIX)) begin : g_awCheck
      $error("cam_capture_gen2: AW too small for IMG_W*IMG_H");
    end
  endgenerate

  logic [1:0]    r_pclkSync, r_vsSync, r_hrefSync;
  logic [7:0]    r_dataMeta, r_dataSync;
  logic          r_pclkPrev, r_vsPrev, r_hrefPrev;
  logic          w_pclkRise, w_hrefFall, w_vsFall, w_vsRise;

  capState_t     r_state;
  logic          r_cont;
  logic [1:0]    r_decimMask;
  logic [IW-1:0] r_pixIdx;
  logic [1:0]    r_col, r_row;
  logic          r_busy, r_done, r_error, r_memWe;
  logic [7:0]    r_frameCnt;
  logic [AW-1:0] r_memAddr;
  logic [DW-1:0] r_memData;

  logic          w_wordValid, w_oddByte, w_keep, w_wrStrobe;
  logic [DW-1:0] w_px;

  // Data rides the same two stages as pclk so the byte lines up with the detected edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pclkSync <= '0;
      r_vsSync   <= '0;
      r_hrefSync <= '0;
      r_dataMeta <= '0;
      r_dataSync <= '0;
      r_pclkPrev <= 1'b0;
      r_vsPrev   <= 1'b0;
      r_hrefPrev <= 1'b0;
    end else begin
      r_pclkSync <= {r_pclkSync[0], cam_pclk};
      r_vsSync   <= {r_vsSync[0], cam_vsync};
      r_hrefSync <= {r_hrefSync[0], cam_href};
      r_dataMeta <= cam_px_data;
      r_dataSync <= r_dataMeta;
      r_pclkPrev <= r_pclkSync[1];
      r_vsPrev   <= r_vsSync[1];
      r_hrefPrev <= r_hrefSync[1];
    end
  end

  assign w_pclkRise = r_pclkSync[1] & ~r_pclkPrev;
  assign w_hrefFall = ~r_hrefSync[1] & r_hrefPrev;
  assign w_vsFall   = ~r_vsSync[1] & r_vsPrev;
  assign w_vsRise   = r_vsSync[1] & ~r_vsPrev;

  cam_px_pack #(.DW(DW)) u_pack (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == WAIT_VS),
    .i_en        (r_state == CAPTURE),
    .i_pclkRise  (w_pclkRise),
    .i_href      (r_hrefSync[1]),
    .i_hrefFall  (w_hrefFall),
    .i_data      (r_dataSync),
    .o_wordValid (w_wordValid),
    .o_px        (w_px),
    .o_oddByte   (w_oddByte)
  );

  // Only the low two bits of row/col matter for mod-1/2/4 decimation.
  assign w_keep     = ((r_col & r_decimMask) == 2'b00) && ((r_row & r_decimMask) == 2'b00);
  assign w_wrStrobe = w_wordValid && w_keep && (r_pixIdx < NPIX_V);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cont      <= 1'b0;
      r_decimMask <= 2'b00;
      r_pixIdx    <= '0;
      r_col       <= 2'b00;
      r_row       <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_memWe     <= 1'b0;
      r_frameCnt  <= 8'd0;
      r_memAddr   <= '0;
      r_memData   <= '0;
    end else begin
      r_memWe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init) begin
            r_cont      <= continuous;
            r_decimMask <= decimMask(decim);
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          r_done    <= 1'b0;
          r_pixIdx  <= '0;
          r_col     <= 2'b00;
          r_row     <= 2'b00;
          r_memAddr <= '0;
          if (w_vsFall) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_wordValid) begin
            r_col <= r_col + 2'd1;
            if (w_keep && (r_pixIdx != '1)) r_pixIdx <= r_pixIdx + IW'(1);
          end
          if (w_wrStrobe) begin
            r_memWe   <= 1'b1;
            r_memAddr <= r_pixIdx[AW-1:0];
            r_memData <= w_px;
          end
          if (w_hrefFall) begin
            r_row <= r_row + 2'd1;
            r_col <= 2'b00;
          end
          if (w_vsRise) r_state <= DONE;
        end
        DONE: begin
          r_error    <= (r_pixIdx != NPIX_V) | w_oddByte;
          r_frameCnt <= r_frameCnt + 8'd1;
          r_done     <= 1'b1;
          if (r_cont && init) begin
            r_state <= WAIT_VS;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign frame_cnt = r_frameCnt;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_data  = r_memData;

`ifdef CAM_CAPTURE_CKSUM_EN
  logic [15:0] r_cksum;
  logic        w_enterWaitVs;

  assign w_enterWaitVs = ((r_state == IDLE) && init) || ((r_state == DONE) && r_cont && init);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cksum <= 16'd0;
    end else if (w_enterWaitVs) begin
      r_cksum <= 16'd0;
    end else if ((r_state == CAPTURE) && w_wrStrobe) begin
      r_cksum <= r_cksum + 16'(w_px);
    end
  end

  assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_cam_capture_gen2.sv
// Directed bench for cam_capture_gen2 using a reduced 8x4 output frame and three DW variants.
`timescale 1ns/1ps
module tb_cam_capture_gen2;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int AW    = 5;

  typedef struct {
    logic [1:0]  decim;
    int          dFactor;
    int          widthW;
    int          lines;
    int          oddLine;
    logic        pc;
    logic [15:0] cv;
    int          expWrites;
    int          expLastAddr;
    logic        expError;
  } vec_t;

  logic clk = 1'b0;
  logic rst, init, continuous;
  logic [1:0] decim;
  logic cam_pclk, cam_vsync, cam_href;
  logic [7:0] cam_px_data;

  logic busy, done, error, mem_we;
  logic [7:0] frame_cnt;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_data16;
  logic busy8, done8, error8, mem_we8;
  logic [7:0] frame_cnt8;
  logic [AW-1:0] mem_addr8;
  logic [7:0] mem_data8;
  logic busy12, done12, error12, mem_we12;
  logic [7:0] frame_cnt12;
  logic [AW-1:0] mem_addr12;
  logic [11:0] mem_data12;
`ifdef CAM_CAPTURE_CKSUM_EN
  logic [15:0] cksum16, cksum8, cksum12;
`endif

  always #5 clk = ~clk;

  cam_capture_gen2 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(16)) dut16 (
    .clk(clk), .rst(rst), .init(init), .continuous(continuous), .decim(decim),
    .busy(busy), .done(done), .error(error), .frame_cnt(frame_cnt),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_px_data(cam_px_data),
    .mem_addr(mem_addr), .mem_data(mem_data16),
`ifdef CAM_CAPTURE_CKSUM_EN
    .mem_we(mem_we), .cksum(cksum16)
`else
    .mem_we(mem_we)
`endif
  );

  cam_capture_gen2 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(8)) dut8 (
    .clk(clk), .rst(rst), .init(init), .continuous(continuous), .decim(decim),
    .busy(busy8), .done(done8), .error(error8), .frame_cnt(frame_cnt8),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_px_data(cam_px_data),
    .mem_addr(mem_addr8), .mem_data(mem_data8),
`ifdef CAM_CAPTURE_CKSUM_EN
    .mem_we(mem_we8), .cksum(cksum8)
`else
    .mem_we(mem_we8)
`endif
  );

  cam_capture_gen2 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(12)) dut12 (
    .clk(clk), .rst(rst), .init(init), .continuous(continuous), .decim(decim),
    .busy(busy12), .done(done12), .error(error12), .frame_cnt(frame_cnt12),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_px_data(cam_px_data),
    .mem_addr(mem_addr12), .mem_data(mem_data12),
`ifdef CAM_CAPTURE_CKSUM_EN
    .mem_we(mem_we12), .cksum(cksum12)
`else
    .mem_we(mem_we12)
`endif
  );

  int nChecks = 0;
  int nPass = 0;

  int wrTotal = 0;
  int dataErrs = 0;
  int sideErrs = 0;
  int doneRises = 0;
  int doneCycles = 0;
  int frameBase = 0;
  int curD = 1;
  logic patConst = 1'b0;
  logic [15:0] constVal = 16'h0000;
  logic prevDone = 1'b0;
  logic [15:0] lastData16 = 16'h0;
  logic [7:0] lastData8 = 8'h0;
  logic [11:0] lastData12 = 12'h0;
  logic [AW-1:0] lastAddr = '0;

  // Scoreboard: every write is compared with the pixel the sensor pattern puts at that index.
  always @(negedge clk) begin
    int k;
    logic [7:0] r8, c8;
    logic [15:0] expW;
    if (mem_we) begin
      k = wrTotal - frameBase;
      r8 = 8'((k / IMG_W) * curD);
      c8 = 8'((k % IMG_W) * curD);
      expW = patConst ? constVal : {r8, c8};
      if (mem_addr != AW'(k) || mem_data16 != expW ||
          mem_data8 != {expW[15:13], expW[10:8], expW[4:3]} ||
          mem_data12 != {expW[15:12], expW[10:7], expW[4:1]})
        dataErrs++;
      wrTotal++;
      lastData16 = mem_data16;
      lastData8 = mem_data8;
      lastData12 = mem_data12;
      lastAddr = mem_addr;
    end
    if ({mem_we8, mem_we12, busy8, busy12, done8, done12, error8, error12} !=
        {mem_we, mem_we, busy, busy, done, done, error, error} ||
        frame_cnt8 != frame_cnt || frame_cnt12 != frame_cnt ||
        mem_addr8 != mem_addr || mem_addr12 != mem_addr)
      sideErrs++;
    if (done && !prevDone) doneRises++;
    if (done) doneCycles++;
    prevDone = done;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic sendByte(input logic [7:0] b);
    cam_px_data = b;
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendFrame(input int widthW, input int lines, input int oddLine);
    logic [15:0] w;
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    for (int r = 0; r < lines; r++) begin
      cam_href = 1'b1;
      for (int c = 0; c < widthW; c++) begin
        w = patConst ? constVal : {r[7:0], c[7:0]};
        sendByte(w[15:8]);
        sendByte(w[7:0]);
      end
      if (r == oddLine) sendByte(8'hAA);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    cam_vsync = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    decim = v.decim;
    continuous = 1'b0;
    curD = v.dFactor;
    patConst = v.pc;
    constVal = v.cv;
    frameBase = wrTotal;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    sendFrame(v.widthW, v.lines, v.oddLine);
  endtask

  vec_t vecs[8];
  int errBase, wrBase, dr0, dc0, fcBase;

  initial begin
    vecs[0] = '{2'b00, 1, 8, 4, -1, 1'b0, 16'h0000, 32, 31, 1'b0};
    vecs[1] = '{2'b01, 2, 16, 8, -1, 1'b0, 16'h0000, 32, 31, 1'b0};
    vecs[2] = '{2'b10, 4, 32, 16, -1, 1'b0, 16'h0000, 32, 31, 1'b0};
    vecs[3] = '{2'b11, 1, 8, 4, -1, 1'b0, 16'h0000, 32, 31, 1'b0};
    vecs[4] = '{2'b00, 1, 8, 3, -1, 1'b0, 16'h0000, 24, 23, 1'b1};
    vecs[5] = '{2'b00, 1, 8, 6, -1, 1'b0, 16'h0000, 32, 31, 1'b1};
    vecs[6] = '{2'b00, 1, 8, 4, 0, 1'b0, 16'h0000, 32, 31, 1'b1};
    vecs[7] = '{2'b00, 1, 8, 4, -1, 1'b1, 16'hF81F, 32, 31, 1'b0};

    rst = 1'b0; init = 1'b0; continuous = 1'b0; decim = 2'b00;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_px_data = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      errBase = dataErrs;
      wrBase = wrTotal;
      applyStimulus(vecs[i]);
      $display("[TB] vector %0d done", i);
      checkOutput($sformatf("v%0d writes", i), 32'(wrTotal - wrBase), 32'(vecs[i].expWrites));
      checkOutput($sformatf("v%0d last addr", i), 32'(lastAddr), 32'(vecs[i].expLastAddr));
      checkOutput($sformatf("v%0d data errors", i), 32'(dataErrs - errBase), 32'd0);
      checkOutput($sformatf("v%0d error", i), 32'(error), 32'(vecs[i].expError));
      checkOutput($sformatf("v%0d done", i), 32'(done), 32'd1);
      checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), 32'(i + 1));
    end

    checkOutput("fmt565 F81F", 32'(lastData16), 32'h0000F81F);
    checkOutput("fmt332 F81F", 32'(lastData8), 32'h000000E3);
    checkOutput("fmt444 F81F", 32'(lastData12), 32'h00000F0F);

    // Continuous: three frames back-to-back with init held, then init drops during the fourth.
    continuous = 1'b1; decim = 2'b00; curD = 1; patConst = 1'b0;
    init = 1'b1;
    repeat (2) @(negedge clk);
    dr0 = doneRises; dc0 = doneCycles; wrBase = wrTotal; errBase = dataErrs;
    fcBase = 32'(frame_cnt);
    for (int f = 0; f < 3; f++) begin
      frameBase = wrTotal;
      sendFrame(8, 4, -1);
    end
    checkOutput("cont done pulses", 32'(doneRises - dr0), 32'd3);
    checkOutput("cont done width", 32'(doneCycles - dc0), 32'd3);
    checkOutput("cont frame_cnt", 32'(frame_cnt), 32'(fcBase + 3));
    checkOutput("cont busy", 32'(busy), 32'd1);
    checkOutput("cont writes", 32'(wrTotal - wrBase), 32'd96);
    checkOutput("cont data errors", 32'(dataErrs - errBase), 32'd0);
    frameBase = wrTotal;
    fork
      sendFrame(8, 4, -1);
      begin
        repeat (60) @(negedge clk);
        init = 1'b0;
      end
    join
    checkOutput("cont stop busy", 32'(busy), 32'd0);
    checkOutput("cont stop done", 32'(done), 32'd1);
    checkOutput("cont stop frame_cnt", 32'(frame_cnt), 32'(fcBase + 4));
    checkOutput("cont stop error", 32'(error), 32'd0);
    wrBase = wrTotal;
    sendFrame(8, 4, -1);
    checkOutput("idle no writes", 32'(wrTotal - wrBase), 32'd0);
    checkOutput("idle frame_cnt", 32'(frame_cnt), 32'(fcBase + 4));
    continuous = 1'b0;

`ifdef CAM_CAPTURE_CKSUM_EN
    applyStimulus('{2'b00, 1, 8, 4, -1, 1'b1, 16'h0001, 32, 31, 1'b0});
    checkOutput("cksum const 1", 32'(cksum16), 32'h00000020);
`endif

    // Mid-line reset: two words into a line, pull reset and confirm nothing more is written.
    patConst = 1'b0; curD = 1; frameBase = wrTotal;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    cam_href = 1'b1;
    for (int b = 0; b < 5; b++) sendByte(8'(b));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset mem_we", 32'(mem_we), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset frame_cnt", 32'(frame_cnt), 32'd0);
    wrBase = wrTotal;
    @(negedge clk);
    rst = 1'b1;
    for (int b = 0; b < 6; b++) sendByte(8'(b));
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midreset no writes", 32'(wrTotal - wrBase), 32'd0);
    checkOutput("midreset still idle", 32'(busy), 32'd0);
    checkOutput("dw variants agree", 32'(sideErrs), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
